// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-ID encodings, length width, injector states.
package noc_pkg;

    localparam int LEN_W = 12;

    // Flit-ID one-hot encodings. The arbiter timer decodes FLIT_HEAD.
    localparam logic [2:0] FLIT_IDLE = 3'b000;
    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } inj_state_e;

endpackage

// File: rtl/packet_injector.sv
// Local-port packet injector: frames a core payload stream into a header
// flit plus body/tail flits for one arbiter port, stalling on lost grant.
module packet_injector #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = noc_pkg::LEN_W,
    parameter int SLACK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic [DATA_W-1:0] flit_data,
    output logic              flit_valid,
    output logic              busy,
    output logic              done
);
    import noc_pkg::*;

    // Header flit plus grant/bubble slack on top of the payload count.
    localparam logic [LEN_W:0] OVERHEAD = (LEN_W+1)'(SLACK + 1);

    inj_state_e        state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  budget_q;
    logic [LEN_W-1:0]  len_q;
    logic              done_q;

    logic [LEN_W:0]    budget_wide;
    logic [LEN_W-1:0]  budget_d;
    logic              xfer;
    logic              last;

    // Timeout budget, widened by one bit so the saturation check sees overflow.
    always_comb begin
        budget_wide = {1'b0, pkt_len} + OVERHEAD;
        budget_d    = budget_wide[LEN_W] ? {LEN_W{1'b1}} : budget_wide[LEN_W-1:0];
    end

    assign xfer = (state_q == ST_BODY) && grant && in_valid;
    assign last = (rem_q == LEN_W'(1));

    // Packet FSM: latches length/budget on start, counts payload words down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            budget_q <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && (pkt_len != '0)) begin
                        rem_q    <= pkt_len;
                        len_q    <= pkt_len;
                        budget_q <= budget_d;
                        state_q  <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (grant) state_q <= ST_BODY;
                end
                ST_BODY: begin
                    if (xfer) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (last) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Flit-side outputs; req/busy/length depend only on registered state so
    // grant never reaches req combinationally.
    always_comb begin
        req        = (state_q != ST_IDLE);
        busy       = (state_q != ST_IDLE);
        done       = done_q;
        length     = '0;
        flit_id    = FLIT_IDLE;
        flit_data  = '0;
        flit_valid = 1'b0;
        in_ready   = 1'b0;
        case (state_q)
            ST_HEAD: begin
                // Header is presented even without grant so the timer can latch it.
                length     = budget_q;
                flit_id    = FLIT_HEAD;
                flit_data  = DATA_W'(len_q);
                flit_valid = grant;
            end
            ST_BODY: begin
                in_ready = grant;
                if (xfer) begin
                    flit_id    = last ? FLIT_TAIL : FLIT_BODY;
                    flit_data  = in_data;
                    flit_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_packet_injector.sv
// Bench for packet_injector: directed cycle table plus randomized packets
// checked against a flit-transcript scoreboard.
module tb_packet_injector;

    localparam int DW = 32;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, grant;
    logic [LW-1:0] pkt_len;
    logic [DW-1:0] in_data;
    logic          in_ready, req, flit_valid, busy, done;
    logic [2:0]    flit_id;
    logic [LW-1:0] length;
    logic [DW-1:0] flit_data;

    int checks = 0;
    int errors = 0;

    packet_injector #(.DATA_W(DW), .LEN_W(LW), .SLACK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .grant(grant), .req(req), .flit_id(flit_id), .length(length),
        .flit_data(flit_data), .flit_valid(flit_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rst, start;
        logic [LW-1:0] len;
        logic [DW-1:0] data;
        logic          vld, gnt;
        logic          req;
        logic [2:0]    id;
        logic          fv, ir;
        logic [DW-1:0] fd;
        logic [LW-1:0] lng;
        logic          busy, done;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(logic r, logic s, logic [LW-1:0] l, logic [DW-1:0] d,
                              logic vl, logic g, logic rq, logic [2:0] id, logic fv,
                              logic ir, logic [DW-1:0] fd, logic [LW-1:0] lng,
                              logic b, logic dn);
        vec_t e;
        e.rst = r; e.start = s; e.len = l; e.data = d; e.vld = vl; e.gnt = g;
        e.req = rq; e.id = id; e.fv = fv; e.ir = ir; e.fd = fd; e.lng = lng;
        e.busy = b; e.done = dn;
        tbl.push_back(e);
    endfunction

    // Reset-state row: IDLE, nothing driven
    function automatic void idle_row(logic s, logic [LW-1:0] l, logic dn);
        v(0, s, l, 32'hDEAD_BEEF, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0, dn);
    endfunction

    typedef struct { logic [2:0] id; logic [DW-1:0] d; } flit_t;

    initial begin
        // ---------------- directed table ----------------
        idle_row(0, 0, 0);
        // N=3, A,B,C with grant/valid held
        idle_row(1, 3, 0);
        v(0,0,0,32'hA,1,1, 1,3'b001,1,0,32'd3,12'd8,1,0);
        v(0,0,0,32'hA,1,1, 1,3'b010,1,1,32'hA,0,1,0);
        v(0,0,0,32'hB,1,1, 1,3'b010,1,1,32'hB,0,1,0);
        v(0,0,0,32'hC,1,1, 1,3'b100,1,1,32'hC,0,1,0);
        idle_row(0, 0, 1);
        idle_row(0, 0, 0);
        // N=1: header then tail directly
        idle_row(1, 1, 0);
        v(0,0,0,32'hD,1,1, 1,3'b001,1,0,32'd1,12'd6,1,0);
        v(0,0,0,32'hD,1,1, 1,3'b100,1,1,32'hD,0,1,0);
        idle_row(0, 0, 1);
        // N=5, grant withdrawn for 3 cycles after the 2nd word
        idle_row(1, 5, 0);
        v(0,0,0,32'h11,1,1, 1,3'b001,1,0,32'd5,12'd10,1,0);
        v(0,0,0,32'h11,1,1, 1,3'b010,1,1,32'h11,0,1,0);
        v(0,0,0,32'h22,1,1, 1,3'b010,1,1,32'h22,0,1,0);
        for (int i = 0; i < 3; i++)
            v(0,0,0,32'h33,1,0, 1,3'b000,0,0,0,0,1,0);
        v(0,0,0,32'h33,1,1, 1,3'b010,1,1,32'h33,0,1,0);
        v(0,0,0,32'h44,1,1, 1,3'b010,1,1,32'h44,0,1,0);
        v(0,0,0,32'h55,1,1, 1,3'b100,1,1,32'h55,0,1,0);
        idle_row(0, 0, 1);
        // N=2 with two bubbles (in_valid low, grant high)
        idle_row(1, 2, 0);
        v(0,0,0,32'h66,0,1, 1,3'b001,1,0,32'd2,12'd7,1,0);
        v(0,0,0,32'h66,0,1, 1,3'b000,0,1,0,0,1,0);
        v(0,0,0,32'h66,0,1, 1,3'b000,0,1,0,0,1,0);
        v(0,0,0,32'h66,1,1, 1,3'b010,1,1,32'h66,0,1,0);
        v(0,0,0,32'h77,1,1, 1,3'b100,1,1,32'h77,0,1,0);
        idle_row(0, 0, 1);
        // N=0 ignored; N=4095 saturates budget; reset while in HEAD
        v(0,1,0,0,1,0, 0,3'b000,0,0,0,0,0,0);
        v(0,1,12'd4095,0,1,0, 0,3'b000,0,0,0,0,0,0);
        v(0,0,0,0,1,0, 1,3'b001,0,0,32'd4095,12'd4095,1,0);
        v(1,0,0,0,1,0, 1,3'b001,0,0,32'd4095,12'd4095,1,0);
        idle_row(0, 0, 0);
        // reset in BODY with rem=2, then a fresh packet
        idle_row(1, 3, 0);
        v(0,0,0,32'h91,1,1, 1,3'b001,1,0,32'd3,12'd8,1,0);
        v(0,0,0,32'h91,1,1, 1,3'b010,1,1,32'h91,0,1,0);
        v(1,0,0,32'h92,1,0, 1,3'b000,0,0,0,0,1,0);
        idle_row(0, 0, 0);
        idle_row(1, 2, 0);
        v(0,0,0,32'hA1,1,1, 1,3'b001,1,0,32'd2,12'd7,1,0);
        v(0,0,0,32'hA1,1,1, 1,3'b010,1,1,32'hA1,0,1,0);
        v(0,0,0,32'hA2,1,1, 1,3'b100,1,1,32'hA2,0,1,0);
        idle_row(0, 0, 1);

        rst = 1; start = 0; pkt_len = 0; in_data = 0; in_valid = 0; grant = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; start = tbl[i].start; pkt_len = tbl[i].len;
            in_data = tbl[i].data; in_valid = tbl[i].vld; grant = tbl[i].gnt;
            #1;
            chk($sformatf("row%0d.req", i),        req,        tbl[i].req);
            chk($sformatf("row%0d.flit_id", i),    flit_id,    tbl[i].id);
            chk($sformatf("row%0d.flit_valid", i), flit_valid, tbl[i].fv);
            chk($sformatf("row%0d.in_ready", i),   in_ready,   tbl[i].ir);
            chk($sformatf("row%0d.flit_data", i),  flit_data,  tbl[i].fd);
            chk($sformatf("row%0d.length", i),     length,     tbl[i].lng);
            chk($sformatf("row%0d.busy", i),       busy,       tbl[i].busy);
            chk($sformatf("row%0d.done", i),       done,       tbl[i].done);
        end

        // ---------------- randomized packets vs transcript ----------------
        for (int p = 0; p < 40; p++) begin
            int            n;
            int            idx;
            int            cyc;
            bit            got_tail;
            logic [DW-1:0] words[$];
            flit_t         expq[$];
            flit_t         f;

            n = (p % 10 == 9) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 8));
            words.delete(); expq.delete();
            f.id = 3'b001; f.d = DW'(n); expq.push_back(f);
            for (int k = 0; k < n; k++) begin
                words.push_back($urandom);
                f.id = (k == n-1) ? 3'b100 : 3'b010;
                f.d  = words[k];
                expq.push_back(f);
            end

            @(negedge clk);
            rst = 0; start = 1; pkt_len = LW'(n); grant = $urandom_range(0, 1);
            in_valid = 0; in_data = 0;
            #1;
            chk("rnd.idle_req", req, 1'b0);

            idx = 0; cyc = 0; got_tail = 0;
            while (!got_tail && cyc < 400) begin
                @(negedge clk);
                start    = ($urandom_range(0, 4) == 0);
                pkt_len  = LW'($urandom_range(0, 9));
                grant    = ($urandom_range(0, 3) != 0);
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = (idx < n) ? words[idx] : 32'h0;
                #1;
                chk("rnd.req_held", req, 1'b1);
                if (flit_valid) begin
                    chk("rnd.fv_needs_grant", grant, 1'b1);
                    if (expq.size() == 0) begin
                        chk("rnd.extra_flit", flit_id, 3'b000);
                    end else begin
                        f = expq.pop_front();
                        chk("rnd.flit_id", flit_id, f.id);
                        chk("rnd.flit_data", flit_data, f.d);
                        if (f.id == 3'b001)
                            chk("rnd.length", length, (n + 5 > 4095) ? 4095 : n + 5);
                        if (f.id == 3'b100) got_tail = 1;
                    end
                end else begin
                    chk("rnd.bubble_id", flit_id, (flit_id == 3'b001) ? 3'b001 : 3'b000);
                end
                if (in_ready && in_valid) begin
                    chk("rnd.consume_is_flit", flit_valid, 1'b1);
                    idx++;
                end
                cyc++;
            end
            if (!got_tail) begin
                errors++;
                $display("FAIL rnd.timeout packet %0d sent %0d of %0d words", p, idx, n);
            end

            @(negedge clk);
            start = 0; grant = 0; in_valid = 0;
            #1;
            chk("rnd.done", done, 1'b1);
            chk("rnd.req_drop", req, 1'b0);
            chk("rnd.busy_drop", busy, 1'b0);
            chk("rnd.all_flits", expq.size(), 0);
            chk("rnd.words_used", idx, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
